// File: rtl/cpu_mem_pkg.sv
// cpu_mem_pkg
// Shared types and helpers for the CPU memory-side blocks.
//   write_entry_t : one buffered store {word address, data, byte enables}
//   byte_merge    : per-byte overlay of new_data onto old_data under be
package cpu_mem_pkg;

  typedef struct packed {
    logic [29:0] word_addr;
    logic [31:0] data;
    logic [3:0]  be;
  } write_entry_t;

  function automatic logic [31:0] byte_merge(
    input logic [31:0] old_data,
    input logic [31:0] new_data,
    input logic [3:0]  be
  );
    logic [31:0] w_res;
    w_res = old_data;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) w_res[8*i +: 8] = new_data[8*i +: 8];
    end
    return w_res;
  endfunction

endpackage

// File: rtl/write_buffer.sv
// write_buffer
// Posted-write FIFO between the CPU store unit and the system bus. Stores are
// buffered (up to DEPTH) and drained in order; a store to the same word as the
// youngest non-head entry is merged into it. A probe port reports whether a
// load address matches any buffered word.
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   in_ready                   buffer can take a store this cycle
//   in_write_req/in_addr/in_data/in_byte_enable   store unit request
//   bus_ready                  bus accepts presented write
//   bus_write_req/bus_addr/bus_write_data/bus_byte_enable   head entry to bus
//   probe_addr / probe_hit     read-after-write hazard check
//   empty                      no buffered writes
module write_buffer
  import cpu_mem_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  output logic        in_ready,
  input  logic        in_write_req,
  input  logic [31:0] in_addr,
  input  logic [31:0] in_data,
  input  logic [3:0]  in_byte_enable,
  input  logic        bus_ready,
  output logic        bus_write_req,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_write_data,
  output logic [3:0]  bus_byte_enable,
  input  logic [31:0] probe_addr,
  output logic        probe_hit,
  output logic        empty
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] DEPTH_C = (PW+1)'(DEPTH);

  write_entry_t  r_mem [DEPTH];
  logic [PW-1:0] r_head;
  logic [PW-1:0] r_tail;
  logic [PW:0]   r_count;

  logic          w_xfer;
  logic          w_merge;
  logic          w_push;
  logic          w_pop;
  logic [PW-1:0] w_tail_m1;
  logic [DEPTH-1:0] w_hit;

  assign in_ready  = (r_count != DEPTH_C);
  assign empty     = (r_count == '0);
  assign w_xfer    = in_write_req && in_ready;
  assign w_tail_m1 = r_tail - 1'b1;

  // count >= 2 guarantees the youngest entry is not the head, which may be
  // mid-transfer on the bus and must not change under it.
  assign w_merge = w_xfer && (r_count >= (PW+1)'(2)) &&
                   (r_mem[w_tail_m1].word_addr == in_addr[31:2]);
  assign w_push  = w_xfer && !w_merge;
  assign w_pop   = bus_write_req && bus_ready;

  assign bus_write_req   = (r_count != '0);
  assign bus_addr        = {r_mem[r_head].word_addr, 2'b00};
  assign bus_write_data  = r_mem[r_head].data;
  assign bus_byte_enable = r_mem[r_head].be;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (w_merge) begin
        r_mem[w_tail_m1].data <= byte_merge(r_mem[w_tail_m1].data, in_data, in_byte_enable);
        r_mem[w_tail_m1].be   <= r_mem[w_tail_m1].be | in_byte_enable;
      end else if (w_push) begin
        r_mem[r_tail] <= '{word_addr: in_addr[31:2], data: in_data, be: in_byte_enable};
      end
      if (w_push) r_tail <= r_tail + 1'b1;
      if (w_pop)  r_head <= r_head + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // An entry is valid when its distance from head is below count; an entry
  // popping this cycle is still counted, so it still reports a hit.
  for (genvar g = 0; g < DEPTH; g++) begin : g_probe
    logic [PW-1:0] w_off;
    assign w_off    = PW'(g) - r_head;
    assign w_hit[g] = ({1'b0, w_off} < r_count) &&
                      (r_mem[g].word_addr == probe_addr[31:2]);
  end

  assign probe_hit = |w_hit;

endmodule

// File: tb/tb_write_buffer.sv
// tb_write_buffer
// Directed vector table (one row per cycle) plus hand sequences for
// fill/backpressure and reset mid-drain.
module tb_write_buffer;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_ready;
  logic        in_write_req;
  logic [31:0] in_addr;
  logic [31:0] in_data;
  logic [3:0]  in_byte_enable;
  logic        bus_ready;
  logic        bus_write_req;
  logic [31:0] bus_addr;
  logic [31:0] bus_write_data;
  logic [3:0]  bus_byte_enable;
  logic [31:0] probe_addr;
  logic        probe_hit;
  logic        empty;

  int n_total = 0;
  int n_pass  = 0;

  always #5 clk = ~clk;

  write_buffer #(.DEPTH(4)) dut (
    .clk             (clk),
    .reset           (reset),
    .in_ready        (in_ready),
    .in_write_req    (in_write_req),
    .in_addr         (in_addr),
    .in_data         (in_data),
    .in_byte_enable  (in_byte_enable),
    .bus_ready       (bus_ready),
    .bus_write_req   (bus_write_req),
    .bus_addr        (bus_addr),
    .bus_write_data  (bus_write_data),
    .bus_byte_enable (bus_byte_enable),
    .probe_addr      (probe_addr),
    .probe_hit       (probe_hit),
    .empty           (empty)
  );

  typedef struct {
    string       name;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
    logic        brdy;
    logic [31:0] probe;
    logic        e_inrdy;
    logic        e_req;
    logic [31:0] e_addr;
    logic [31:0] e_data;
    logic [3:0]  e_be;
    logic        e_hit;
    logic        e_empty;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp)
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    else
      n_pass++;
  endtask

  function automatic vec_t mk(input string n, input logic wr, input logic [31:0] a,
                              input logic [31:0] d, input logic [3:0] be, input logic br,
                              input logic [31:0] pr, input logic ir, input logic rq,
                              input logic [31:0] ea, input logic [31:0] ed,
                              input logic [3:0] eb, input logic hit, input logic emp);
    vec_t v;
    v.name = n; v.wr = wr; v.addr = a; v.data = d; v.be = be; v.brdy = br;
    v.probe = pr; v.e_inrdy = ir; v.e_req = rq; v.e_addr = ea; v.e_data = ed;
    v.e_be = eb; v.e_hit = hit; v.e_empty = emp;
    return v;
  endfunction

  task automatic idle_inputs();
    in_write_req = 0; in_addr = 0; in_data = 0; in_byte_enable = 0;
    bus_ready = 0; probe_addr = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle_inputs();
    reset = 1;
    @(negedge clk);
    reset = 0;
  endtask

  initial begin
    logic [31:0] fa [5];
    logic [31:0] fd [5];
    int got;
    logic acc5;
    logic seen_req;

    reset = 1;
    idle_inputs();
    @(negedge clk);
    @(negedge clk);
    reset = 0;

    // reset state
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_req", 32'(bus_write_req), 32'd0);
    chk("rst_addr", bus_addr, 32'h0);
    chk("rst_data", bus_write_data, 32'h0);
    chk("rst_be", 32'(bus_byte_enable), 32'h0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_hit", 32'(probe_hit), 32'd0);

    //            name        wr addr       data         be   br probe      ir rq e_addr     e_data       e_be hit emp
    vecs.push_back(mk("sw_push",  1, 32'h1000, 32'hDEADBEEF, 4'hF, 1, 32'h0,    1, 0, 0, 0, 0, 0, 1));
    vecs.push_back(mk("sw_bus",   0, 32'h0,    32'h0,        4'h0, 1, 32'h1000, 1, 1, 32'h1000, 32'hDEADBEEF, 4'hF, 1, 0));
    vecs.push_back(mk("sw_done",  0, 32'h0,    32'h0,        4'h0, 1, 32'h1000, 1, 0, 0, 0, 0, 0, 1));
    vecs.push_back(mk("mg_p1",    1, 32'h2000, 32'h000000AA, 4'h1, 0, 32'h0,    1, 0, 0, 0, 0, 0, 1));
    vecs.push_back(mk("mg_p2",    1, 32'h3000, 32'h0000BBBB, 4'h3, 0, 32'h0,    1, 1, 32'h2000, 32'h000000AA, 4'h1, 0, 0));
    vecs.push_back(mk("mg_p3",    1, 32'h3000, 32'hCCCC0000, 4'hC, 0, 32'h0,    1, 1, 32'h2000, 32'h000000AA, 4'h1, 0, 0));
    vecs.push_back(mk("mg_hold",  0, 32'h0,    32'h0,        4'h0, 0, 32'h3000, 1, 1, 32'h2000, 32'h000000AA, 4'h1, 1, 0));
    vecs.push_back(mk("mg_d1",    0, 32'h0,    32'h0,        4'h0, 1, 32'h0,    1, 1, 32'h2000, 32'h000000AA, 4'h1, 0, 0));
    vecs.push_back(mk("mg_d2",    0, 32'h0,    32'h0,        4'h0, 1, 32'h0,    1, 1, 32'h3000, 32'hCCCCBBBB, 4'hF, 0, 0));
    vecs.push_back(mk("mg_empty", 0, 32'h0,    32'h0,        4'h0, 0, 32'h0,    1, 0, 0, 0, 0, 0, 1));
    vecs.push_back(mk("nh_p1",    1, 32'h4000, 32'h11111111, 4'hF, 0, 32'h0,    1, 0, 0, 0, 0, 0, 1));
    vecs.push_back(mk("nh_p2",    1, 32'h4000, 32'h22222222, 4'h3, 0, 32'h0,    1, 1, 32'h4000, 32'h11111111, 4'hF, 0, 0));
    vecs.push_back(mk("nh_d1",    0, 32'h0,    32'h0,        4'h0, 1, 32'h0,    1, 1, 32'h4000, 32'h11111111, 4'hF, 0, 0));
    vecs.push_back(mk("nh_d2",    0, 32'h0,    32'h0,        4'h0, 1, 32'h0,    1, 1, 32'h4000, 32'h22222222, 4'h3, 0, 0));
    vecs.push_back(mk("nh_empty", 0, 32'h0,    32'h0,        4'h0, 0, 32'h0,    1, 0, 0, 0, 0, 0, 1));
    vecs.push_back(mk("pr_p1",    1, 32'h5000, 32'h00000050, 4'hF, 0, 32'h0,    1, 0, 0, 0, 0, 0, 1));
    vecs.push_back(mk("pr_p2",    1, 32'h5004, 32'h00000054, 4'hF, 0, 32'h5006, 1, 1, 32'h5000, 32'h00000050, 4'hF, 0, 0));
    vecs.push_back(mk("pr_hit",   0, 32'h0,    32'h0,        4'h0, 0, 32'h5006, 1, 1, 32'h5000, 32'h00000050, 4'hF, 1, 0));
    vecs.push_back(mk("pr_miss",  0, 32'h0,    32'h0,        4'h0, 0, 32'h5008, 1, 1, 32'h5000, 32'h00000050, 4'hF, 0, 0));
    vecs.push_back(mk("pr_pop",   0, 32'h0,    32'h0,        4'h0, 1, 32'h5000, 1, 1, 32'h5000, 32'h00000050, 4'hF, 1, 0));
    vecs.push_back(mk("pr_gone",  0, 32'h0,    32'h0,        4'h0, 1, 32'h5000, 1, 1, 32'h5004, 32'h00000054, 4'hF, 0, 0));
    vecs.push_back(mk("pr_empty", 0, 32'h0,    32'h0,        4'h0, 0, 32'h5004, 1, 0, 0, 0, 0, 0, 1));
    vecs.push_back(mk("be0_push", 1, 32'h6000, 32'h12345678, 4'h0, 0, 32'h0,    1, 0, 0, 0, 0, 0, 1));
    vecs.push_back(mk("be0_bus",  0, 32'h0,    32'h0,        4'h0, 1, 32'h6000, 1, 1, 32'h6000, 32'h12345678, 4'h0, 1, 0));
    vecs.push_back(mk("be0_empty",0, 32'h0,    32'h0,        4'h0, 0, 32'h0,    1, 0, 0, 0, 0, 0, 1));
    vecs.push_back(mk("pp_p1",    1, 32'h7000, 32'h00000070, 4'hF, 0, 32'h0,    1, 0, 0, 0, 0, 0, 1));
    vecs.push_back(mk("pp_both",  1, 32'h7004, 32'h00000074, 4'hF, 1, 32'h0,    1, 1, 32'h7000, 32'h00000070, 4'hF, 0, 0));
    vecs.push_back(mk("pp_d2",    0, 32'h0,    32'h0,        4'h0, 1, 32'h7004, 1, 1, 32'h7004, 32'h00000074, 4'hF, 1, 0));
    vecs.push_back(mk("pp_empty", 0, 32'h0,    32'h0,        4'h0, 0, 32'h0,    1, 0, 0, 0, 0, 0, 1));

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      in_write_req   = vecs[i].wr;
      in_addr        = vecs[i].addr;
      in_data        = vecs[i].data;
      in_byte_enable = vecs[i].be;
      bus_ready      = vecs[i].brdy;
      probe_addr     = vecs[i].probe;
      #1;
      chk({vecs[i].name, ".in_ready"}, 32'(in_ready), 32'(vecs[i].e_inrdy));
      chk({vecs[i].name, ".req"},      32'(bus_write_req), 32'(vecs[i].e_req));
      chk({vecs[i].name, ".hit"},      32'(probe_hit), 32'(vecs[i].e_hit));
      chk({vecs[i].name, ".empty"},    32'(empty), 32'(vecs[i].e_empty));
      if (vecs[i].e_req) begin
        chk({vecs[i].name, ".addr"}, bus_addr, vecs[i].e_addr);
        chk({vecs[i].name, ".data"}, bus_write_data, vecs[i].e_data);
        chk({vecs[i].name, ".be"},   32'(bus_byte_enable), 32'(vecs[i].e_be));
      end
    end

    // Fill and backpressure: five distinct words with bus stalled.
    for (int k = 0; k < 5; k++) begin
      fa[k] = 32'h8000 + 32'(4 * k);
      fd[k] = 32'hA0 + 32'(k);
    end
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      in_write_req = 1; in_addr = fa[k]; in_data = fd[k]; in_byte_enable = 4'hF;
      bus_ready = 0; probe_addr = 0;
      #1;
      chk($sformatf("fill_rdy%0d", k), 32'(in_ready), (k < 4) ? 32'd1 : 32'd0);
    end
    got = 0;
    acc5 = 0;
    for (int cyc = 0; cyc < 30 && got < 5; cyc++) begin
      @(negedge clk);
      bus_ready = 1;
      in_write_req = !acc5;
      #1;
      if (cyc == 0) chk("full_pop_rdy", 32'(in_ready), 32'd0);
      if (in_write_req && in_ready) acc5 = 1;
      if (bus_write_req) begin
        chk($sformatf("drain%0d.addr", got), bus_addr, fa[got]);
        chk($sformatf("drain%0d.data", got), bus_write_data, fd[got]);
        got++;
      end
    end
    chk("drain_count", 32'(got), 32'd5);
    @(negedge clk);
    idle_inputs();
    #1;
    chk("drain_empty", 32'(empty), 32'd1);

    // Reset mid-drain with three entries buffered.
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      in_write_req = 1; in_addr = 32'h9000 + 32'(4 * k); in_data = 32'hF0 + 32'(k);
      in_byte_enable = 4'hF; bus_ready = 0;
    end
    @(negedge clk);
    in_write_req = 0;
    bus_ready = 1;
    reset = 1;
    #1;
    chk("prerst_req", 32'(bus_write_req), 32'd1);
    @(negedge clk);
    reset = 0;
    probe_addr = 32'h9000;
    #1;
    chk("mrst_req", 32'(bus_write_req), 32'd0);
    chk("mrst_addr", bus_addr, 32'h0);
    chk("mrst_data", bus_write_data, 32'h0);
    chk("mrst_be", 32'(bus_byte_enable), 32'h0);
    chk("mrst_empty", 32'(empty), 32'd1);
    chk("mrst_in_ready", 32'(in_ready), 32'd1);
    chk("mrst_hit", 32'(probe_hit), 32'd0);
    seen_req = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      #1;
      if (bus_write_req) seen_req = 1;
    end
    chk("mrst_no_bus", 32'(seen_req), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
